// File: rtl/arcade_input_ctrl.sv
// Arcade input controller: merges PS/2 key latches with joystick inputs,
// produces active-low player controls, stretches coin pulses per player and
// holds DIP-switch / system-mode bytes loaded over the download bus.
module arcade_input_ctrl #(
  parameter int PLAYERS    = 2,
  parameter int BUTTONS    = 3,
  parameter int DSW_BYTES  = 2,
  parameter int COIN_PULSE = 4800000
) (
  input  logic                             clk_sys,
  input  logic                             reset_n,
  input  logic [10:0]                      ps2_key,
  input  logic [16*PLAYERS-1:0]            joystick,
  input  logic                             cabinet,
  input  logic                             ioctl_wr,
  input  logic [7:0]                       ioctl_index,
  input  logic [24:0]                      ioctl_addr,
  input  logic [7:0]                       ioctl_dout,
  output logic [(4+BUTTONS)*PLAYERS-1:0]   inp,
  output logic [PLAYERS-1:0]               start_n,
  output logic [PLAYERS-1:0]               coin_n,
  output logic                             coin_any_n,
  output logic [8*DSW_BYTES-1:0]           dsw,
  output logic [7:0]                       sysmode
);

  // Per-player function index matches the joystick bit layout:
  // 0..3 directions, 4..3+BUTTONS buttons, 4+BUTTONS start, 5+BUTTONS coin.
  localparam int NF      = 6 + BUTTONS;
  localparam int IW      = 4 + BUTTONS;
  localparam int F_START = 4 + BUTTONS;
  localparam int F_COIN  = 5 + BUTTONS;
  localparam int CW      = $clog2(COIN_PULSE + 1);
  // Player 1 index, folded to 0 on single-player builds so selects stay in range.
  localparam int P1      = (PLAYERS >= 2) ? 1 : 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  // Key table entry: {valid, ignore_extended, scan_code}.
  function automatic logic [10:0] key_entry(input int p, input int f);
    logic [10:0] e;
    e = '0;
    if (p == 0) begin
      if (f < 4) begin
        case (f)
          0:       e = {2'b11, 9'h074};
          1:       e = {2'b11, 9'h06B};
          2:       e = {2'b11, 9'h072};
          default: e = {2'b11, 9'h075};
        endcase
      end else if (f == F_START) begin
        e = {2'b10, 9'h016};
      end else if (f == F_COIN) begin
        e = {2'b10, 9'h02E};
      end else begin
        case (f - 4)
          0:       e = {2'b10, 9'h029};
          1:       e = {2'b10, 9'h014};
          2:       e = {2'b10, 9'h011};
          default: e = '0;
        endcase
      end
    end else if (p == 1) begin
      if (f < 4) begin
        case (f)
          0:       e = {2'b10, 9'h034};
          1:       e = {2'b10, 9'h023};
          2:       e = {2'b10, 9'h02B};
          default: e = {2'b10, 9'h02D};
        endcase
      end else if (f == F_START) begin
        e = {2'b10, 9'h01E};
      end else if (f == F_COIN) begin
        e = {2'b10, 9'h036};
      end else begin
        case (f - 4)
          0:       e = {2'b10, 9'h01C};
          1:       e = {2'b10, 9'h01B};
          2:       e = {2'b10, 9'h015};
          default: e = '0;
        endcase
      end
    end
    return e;
  endfunction

  logic                          tog_q, tog_d;
  logic                          key_evt;
  logic [10:0]                   key_ent;
  logic [PLAYERS-1:0][NF-1:0]    key_q, key_d;
  logic [PLAYERS-1:0][NF-1:0]    mrg;
  logic [PLAYERS-1:0]            coin_in;
  logic [(4+BUTTONS)*PLAYERS-1:0] inp_q, inp_d;
  logic [PLAYERS-1:0]            start_n_q, start_n_d;
  logic [PLAYERS-1:0]            coin_n_q, coin_n_d;
  logic                          coin_any_n_q, coin_any_n_d;
  logic [PLAYERS-1:0]            coin_prev_q, coin_prev_d;
  logic [PLAYERS-1:0][1:0]       st_q, st_d;
  logic [PLAYERS-1:0][CW-1:0]    cnt_q, cnt_d;
  logic [8*DSW_BYTES-1:0]        dsw_q, dsw_d;
  logic [7:0]                    sysmode_q, sysmode_d;
  logic                          unused_joy;

  assign unused_joy = ^joystick;

  // Key event detection and key latch update on a matching scan code.
  always_comb begin
    tog_d   = ps2_key[10];
    key_evt = ps2_key[10] ^ tog_q;
    key_d   = key_q;
    key_ent = '0;
    if (key_evt) begin
      for (int p = 0; p < PLAYERS; p++) begin
        for (int f = 0; f < NF; f++) begin
          key_ent = key_entry(p, f);
          if (key_ent[10] && (key_ent[9] ? (ps2_key[7:0] == key_ent[7:0])
                                          : (ps2_key[8:0] == key_ent[8:0]))) begin
            key_d[p][f] = ps2_key[9];
          end
        end
      end
    end
  end

  // Merge key latches with joystick bits per player.
  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      for (int f = 0; f < NF; f++) begin
        mrg[p][f] = key_q[p][f] | joystick[16*p + f];
      end
    end
  end

  // Active-low control outputs, with the upright cabinet sharing player 1 into player 0.
  always_comb begin
    inp_d     = '1;
    start_n_d = '1;
    coin_in   = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      for (int f = 0; f < IW; f++) begin
        inp_d[IW*p + f] = ~(mrg[p][f] |
                            (!cabinet && (PLAYERS >= 2) && (p == 0) && mrg[P1][f]));
      end
      start_n_d[p] = ~mrg[p][F_START];
      coin_in[p]   = mrg[p][F_COIN];
    end
  end

  // Coin stretcher: fixed-length low pulse on a rising edge, then wait for release.
  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    coin_n_d    = coin_n_q;
    coin_prev_d = coin_in;
    for (int p = 0; p < PLAYERS; p++) begin
      case (st_q[p])
        S_IDLE: begin
          coin_n_d[p] = 1'b1;
          if (coin_in[p] && !coin_prev_q[p]) begin
            st_d[p]     = S_PULSE;
            cnt_d[p]    = CW'(COIN_PULSE);
            coin_n_d[p] = 1'b0;
          end
        end
        S_PULSE: begin
          coin_n_d[p] = 1'b0;
          if (cnt_q[p] <= CW'(1)) begin
            cnt_d[p]    = '0;
            coin_n_d[p] = 1'b1;
            st_d[p]     = coin_in[p] ? S_HOLD : S_IDLE;
          end else begin
            cnt_d[p] = cnt_q[p] - CW'(1);
          end
        end
        S_HOLD: begin
          coin_n_d[p] = 1'b1;
          if (!coin_in[p]) st_d[p] = S_IDLE;
        end
        default: begin
          st_d[p]     = S_IDLE;
          cnt_d[p]    = '0;
          coin_n_d[p] = 1'b1;
        end
      endcase
    end
    coin_any_n_d = &coin_n_d;
  end

  // Configuration bytes written over the download bus.
  always_comb begin
    dsw_d     = dsw_q;
    sysmode_d = sysmode_q;
    if (ioctl_wr) begin
      if (ioctl_index == 8'd254) begin
        for (int k = 0; k < DSW_BYTES; k++) begin
          if (ioctl_addr == 25'(k)) dsw_d[8*k +: 8] = ioctl_dout;
        end
      end else if (ioctl_index == 8'd1 && ioctl_addr == 25'd0) begin
        sysmode_d = ioctl_dout;
      end
    end
  end

  // Key toggle register and key latches.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q <= 1'b0;
      key_q <= '0;
    end else begin
      tog_q <= tog_d;
      key_q <= key_d;
    end
  end

  // Registered control outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      inp_q     <= '1;
      start_n_q <= '1;
    end else begin
      inp_q     <= inp_d;
      start_n_q <= start_n_d;
    end
  end

  // Coin stretcher state; previous-coin resets high so a held coin is not an edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      st_q         <= {PLAYERS{S_IDLE}};
      cnt_q        <= '0;
      coin_n_q     <= '1;
      coin_any_n_q <= 1'b1;
      coin_prev_q  <= '1;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      coin_n_q     <= coin_n_d;
      coin_any_n_q <= coin_any_n_d;
      coin_prev_q  <= coin_prev_d;
    end
  end

  // DIP switch and system-mode registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dsw_q     <= '1;
      sysmode_q <= 8'h00;
    end else begin
      dsw_q     <= dsw_d;
      sysmode_q <= sysmode_d;
    end
  end

  assign inp        = inp_q;
  assign start_n    = start_n_q;
  assign coin_n     = coin_n_q;
  assign coin_any_n = coin_any_n_q;
  assign dsw        = dsw_q;
  assign sysmode    = sysmode_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Testbench for arcade_input_ctrl: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the key map,
// control merging, coin stretching and configuration registers.
module tb_arcade_input_ctrl;

  localparam int P  = 2;
  localparam int B  = 3;
  localparam int DB = 2;
  localparam int CP = 5;
  localparam int IW = 4 + B;
  localparam int COIN_BIT = 5 + B;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [10:0]       ps2_key;
  logic [16*P-1:0]   joystick;
  logic              cabinet;
  logic              ioctl_wr;
  logic [7:0]        ioctl_index;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [IW*P-1:0]   inp;
  logic [P-1:0]      start_n;
  logic [P-1:0]      coin_n;
  logic              coin_any_n;
  logic [8*DB-1:0]   dsw;
  logic [7:0]        sysmode;

  arcade_input_ctrl #(.PLAYERS(P), .BUTTONS(B), .DSW_BYTES(DB), .COIN_PULSE(CP)) dut (
    .clk_sys(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
    .cabinet(cabinet), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .inp(inp), .start_n(start_n),
    .coin_n(coin_n), .coin_any_n(coin_any_n), .dsw(dsw), .sysmode(sysmode)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Key map: [player][function], functions right,left,down,up,b0,b1,b2,start,coin.
  logic [8:0] tbl [2][9] = '{
    '{9'h074, 9'h06B, 9'h072, 9'h075, 9'h029, 9'h014, 9'h011, 9'h016, 9'h02E},
    '{9'h034, 9'h023, 9'h02B, 9'h02D, 9'h01C, 9'h01B, 9'h015, 9'h01E, 9'h036}};
  logic [8:0] unmapped [3] = '{9'h05A, 9'h129, 9'h076};

  // Reference model state
  bit          mkey [2][9];
  bit          m_tog;
  int          m_rem [2];
  bit          m_wait [2];
  bit          m_prev [2];
  logic [IW*P-1:0] e_inp;
  logic [P-1:0]    e_start_n;
  logic [P-1:0]    e_coin_n;
  logic            e_any;
  logic [8*DB-1:0] e_dsw;
  logic [7:0]      e_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      for (int f = 0; f < 9; f++) mkey[p][f] = 1'b0;
      m_rem[p] = 0; m_wait[p] = 1'b0; m_prev[p] = 1'b1;
    end
    m_tog = 1'b0;
    e_inp = '1; e_start_n = '1; e_coin_n = '1; e_any = 1'b1;
    e_dsw = '1; e_sys = 8'h00;
  endtask

  function automatic bit lookup(input logic [8:0] code, output int lp, output int lf);
    lp = 0; lf = 0;
    for (int p = 0; p < 2; p++) begin
      for (int f = 0; f < 9; f++) begin
        logic [8:0] t;
        t = tbl[p][f];
        if ((p == 0 && f < 4) ? (code[7:0] == t[7:0]) : (code == t)) begin
          lp = p; lf = f; return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  // Applies one rising clock edge of behaviour to the model.
  task automatic model_edge();
    bit m [2][9];
    bit c;
    int lp, lf;
    for (int p = 0; p < 2; p++)
      for (int f = 0; f < 9; f++) m[p][f] = mkey[p][f] | joystick[16*p + f];
    for (int p = 0; p < 2; p++) begin
      for (int f = 0; f < IW; f++)
        e_inp[IW*p + f] = ~(m[p][f] | (!cabinet && p == 0 && m[1][f]));
      e_start_n[p] = ~m[p][7];
      c = m[p][8];
      if (m_rem[p] > 0) begin
        m_rem[p]--;
        if (m_rem[p] == 0 && c) m_wait[p] = 1'b1;
      end else if (m_wait[p]) begin
        if (!c) m_wait[p] = 1'b0;
      end else if (c && !m_prev[p]) begin
        m_rem[p] = CP;
      end
      m_prev[p] = c;
      e_coin_n[p] = (m_rem[p] == 0);
    end
    e_any = &e_coin_n;
    if (ioctl_wr) begin
      if (ioctl_index == 8'd254 && ioctl_addr < DB) e_dsw[8*int'(ioctl_addr) +: 8] = ioctl_dout;
      if (ioctl_index == 8'd1 && ioctl_addr == 0) e_sys = ioctl_dout;
    end
    if (ps2_key[10] != m_tog) begin
      if (lookup(ps2_key[8:0], lp, lf)) mkey[lp][lf] = ps2_key[9];
    end
    m_tog = ps2_key[10];
  endtask

  task automatic check_all();
    chk("inp",        32'(inp),        32'(e_inp));
    chk("start_n",    32'(start_n),    32'(e_start_n));
    chk("coin_n",     32'(coin_n),     32'(e_coin_n));
    chk("coin_any_n", 32'(coin_any_n), 32'(e_any));
    chk("dsw",        32'(dsw),        32'(e_dsw));
    chk("sysmode",    32'(sysmode),    32'(e_sys));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int low;
    int idx;
    logic [8:0] code;

    reset_n = 1'b0; ps2_key = '0; joystick = '0; cabinet = 1'b1;
    ioctl_wr = 1'b0; ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("rst_inp", 32'(inp), 32'h3FFF);
    chk("rst_dsw", 32'(dsw), 32'hFFFF);
    @(negedge clk) reset_n = 1'b1;
    cycle();

    // Extended up arrow press and release for player 0
    ps2_key = {~ps2_key[10], 1'b1, 9'h175};
    cycle(); chk("kbd_up_lat1", 32'(inp[3]), 32'd1);
    cycle(); chk("kbd_up_press", 32'(inp[3]), 32'd0);
    ps2_key = {~ps2_key[10], 1'b0, 9'h175};
    cycle(); cycle(); chk("kbd_up_release", 32'(inp[3]), 32'd1);

    // Cabinet sharing of player 1 button 0
    joystick[16+4] = 1'b1; cabinet = 1'b0;
    cycle(); chk("cab0_p0b0", 32'(inp[4]), 32'd0); chk("cab0_p1b0", 32'(inp[IW+4]), 32'd0);
    cabinet = 1'b1;
    cycle(); chk("cab1_p0b0", 32'(inp[4]), 32'd1); chk("cab1_p1b0", 32'(inp[IW+4]), 32'd0);
    joystick = '0;
    cycle();

    // Single-cycle coin pulse
    low = 0;
    joystick[COIN_BIT] = 1'b1;
    cycle(); low += int'(!coin_n[0]);
    chk("coin_first", 32'(coin_n[0]), 32'd0); chk("coin_any_first", 32'(coin_any_n), 32'd0);
    joystick[COIN_BIT] = 1'b0;
    for (int i = 0; i < 9; i++) begin cycle(); low += int'(!coin_n[0]); end
    chk("coin_1cyc_len", 32'(low), 32'd5);

    // Second edge inside the pulse does not extend it
    low = 0;
    joystick[COIN_BIT] = 1'b1;
    cycle(); low += int'(!coin_n[0]);
    joystick[COIN_BIT] = 1'b0;
    cycle(); low += int'(!coin_n[0]);
    cycle(); low += int'(!coin_n[0]);
    joystick[COIN_BIT] = 1'b1;
    cycle(); low += int'(!coin_n[0]);
    joystick[COIN_BIT] = 1'b0;
    for (int i = 0; i < 9; i++) begin cycle(); low += int'(!coin_n[0]); end
    chk("coin_retrig_len", 32'(low), 32'd5);

    // Held coin: one pulse, then nothing until release and reassert
    low = 0;
    joystick[COIN_BIT] = 1'b1;
    for (int i = 0; i < 20; i++) begin cycle(); low += int'(!coin_n[0]); end
    chk("coin_hold_len", 32'(low), 32'd5);
    chk("coin_hold_end", 32'(coin_n[0]), 32'd1);
    joystick[COIN_BIT] = 1'b0;
    cycle(); chk("coin_released", 32'(coin_n[0]), 32'd1);
    joystick[COIN_BIT] = 1'b1;
    cycle(); chk("coin_reassert", 32'(coin_n[0]), 32'd0);
    joystick[COIN_BIT] = 1'b0;
    repeat (6) cycle();

    // Configuration download
    ioctl_wr = 1'b1; ioctl_index = 8'd254; ioctl_addr = 25'd1; ioctl_dout = 8'h5A;
    cycle(); chk("dsw_byte1", 32'(dsw[15:8]), 32'h5A);
    ioctl_addr = 25'd7; ioctl_dout = 8'h33;
    cycle(); chk("dsw_oob", 32'(dsw), 32'h5AFF);
    ioctl_index = 8'd1; ioctl_addr = 25'd0; ioctl_dout = 8'h06;
    cycle(); chk("sysmode_wr", 32'(sysmode), 32'h06);
    ioctl_addr = 25'd3; ioctl_dout = 8'h77;
    cycle(); chk("sysmode_other_addr", 32'(sysmode), 32'h06);
    ioctl_wr = 1'b0;
    cycle();

    // Asynchronous reset in the middle of a coin pulse
    joystick[COIN_BIT] = 1'b1;
    cycle(); cycle();
    chk("pre_rst_coin", 32'(coin_n[0]), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_coin_n", 32'(coin_n), 32'h3);
    chk("arst_any", 32'(coin_any_n), 32'd1);
    chk("arst_dsw", 32'(dsw), 32'hFFFF);
    chk("arst_sys", 32'(sysmode), 32'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin cycle(); chk("held_after_rst", 32'(coin_n[0]), 32'd1); end
    joystick[COIN_BIT] = 1'b0;
    cycle();
    joystick[COIN_BIT] = 1'b1;
    cycle(); chk("coin_after_rst", 32'(coin_n[0]), 32'd0);
    joystick = '0;
    repeat (6) cycle();

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(3) == 0) begin
        idx = $urandom_range(20);
        if (idx < 9) code = tbl[0][idx];
        else if (idx < 18) code = tbl[1][idx-9];
        else code = unmapped[idx-18];
        if (idx < 4 && $urandom_range(1) == 1) code = code | 9'h100;
        ps2_key = {~ps2_key[10], 1'($urandom_range(1)), code};
      end
      if ($urandom_range(2) == 0) begin
        idx = 16*$urandom_range(1) + $urandom_range(8);
        joystick[idx] = ~joystick[idx];
      end
      if ($urandom_range(63) == 0) cabinet = ~cabinet;
      ioctl_wr = ($urandom_range(7) == 0);
      case ($urandom_range(3))
        0: ioctl_index = 8'd254;
        1: ioctl_index = 8'd1;
        2: ioctl_index = 8'd0;
        default: ioctl_index = 8'd253;
      endcase
      ioctl_addr = 25'($urandom_range(9));
      ioctl_dout = 8'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
